// File: rtl/vga_ctrl_pkg.sv
// Shared types and constants for the VGA controller slice: code word width,
// scheduler state encoding and the 640x480@60 timing numbers.
package vga_ctrl_pkg;

  // Two RGB444 colours: left in [23:12], right in [11:0].
  localparam int CODE_W = 24;

  // 640x480@60 frame geometry, in pixel clocks and lines.
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;

  // Scheduler state: IDLE = shadow empty, PEND = shadow holds an uncommitted word.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } sched_state_t;

  // Next value of the pointer: after granting req0 the next contention goes to req1.
  function automatic logic rr_next_prefer1(input logic [1:0] gnt);
    return gnt[0];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from the request
// vector; the priority pointer moves only when the granted transfer is taken.
module rr_arb2
  import vga_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // High when requester 1 wins the next contention.
  logic r_prefer1;

  // One-hot grant: a lone requester always wins, contention resolved by pointer.
  always_comb begin
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_prefer1 ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer update on an accepted transfer; reset favours requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prefer1 <= 1'b0;
    end else if (advance) begin
      r_prefer1 <= rr_next_prefer1(gnt);
    end
  end

endmodule

// File: rtl/vga_code_scheduler.sv
// Code word scheduler for the VGA controller. Two requesters arbitrate for a
// single-entry shadow buffer; the buffered word is committed to `code` only
// on a VSYNC falling edge so colour changes never tear mid-frame. Also counts
// frames (VSYNC falling edges) for software pacing.
module vga_code_scheduler
  import vga_ctrl_pkg::*;
#(
  parameter int                CODE_W     = vga_ctrl_pkg::CODE_W,
  parameter logic [CODE_W-1:0] RESET_CODE = 24'h000000,
  parameter int                FCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              req0_valid,
  input  logic [CODE_W-1:0] req0_code,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [CODE_W-1:0] req1_code,
  output logic              req1_ready,
  output logic [CODE_W-1:0] code,
  output logic              commit,
  output logic              pending,
  output logic              last_src,
  output logic [FCNT_W-1:0] frame_cnt
);

  sched_state_t      r_state;
  logic              r_vsync_d;
  logic [CODE_W-1:0] r_shadow;
  logic [CODE_W-1:0] r_code;
  logic              r_commit;
  logic              r_pending;
  logic              r_last_src;
  logic [FCNT_W-1:0] r_frame_cnt;

  logic              w_vs_fall;
  logic              w_open;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_ready0;
  logic              w_ready1;
  logic              w_accept;
  logic              w_acc_src;
  logic [CODE_W-1:0] w_acc_code;

  // Only the first low cycle after a high one counts as an edge.
  assign w_vs_fall = r_vsync_d & ~vsync;

  // Readies may only open while the shadow is empty and reset is released.
  assign w_open = (r_state == ST_IDLE) && !rst;
  assign w_req  = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (w_req),
    .advance (w_accept),
    .gnt     (w_gnt)
  );

  // Ready/accept decode from the arbiter grant; at most one ready is high.
  always_comb begin
    w_ready0   = w_open & w_gnt[0];
    w_ready1   = w_open & w_gnt[1];
    w_accept   = (req0_valid & w_ready0) | (req1_valid & w_ready1);
    w_acc_src  = w_ready1;
    if (w_ready1) begin
      w_acc_code = req1_code;
    end else begin
      w_acc_code = req0_code;
    end
  end

  // VSYNC delay register for falling-edge detection; idles high like VSYNC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_d <= 1'b1;
    end else begin
      r_vsync_d <= vsync;
    end
  end

  // Frame counter: one count per VSYNC falling edge, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_vs_fall) begin
      r_frame_cnt <= r_frame_cnt + {{(FCNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Scheduler FSM: accept into the shadow in IDLE, commit to `code` on the next
  // VSYNC fall in PEND. An accept coinciding with a fall waits a full frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shadow   <= '0;
      r_code     <= RESET_CODE;
      r_commit   <= 1'b0;
      r_pending  <= 1'b0;
      r_last_src <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shadow   <= w_acc_code;
            r_last_src <= w_acc_src;
            r_pending  <= 1'b1;
            r_state    <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (w_vs_fall) begin
            r_code    <= r_shadow;
            r_commit  <= 1'b1;
            r_pending <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_pending <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign code       = r_code;
  assign commit     = r_commit;
  assign pending    = r_pending;
  assign last_src   = r_last_src;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_vga_code_scheduler.sv
// Bench for vga_code_scheduler: directed vector table, hand-written corner
// sequences, then randomized traffic against a frame-level reference model.
module tb_vga_code_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        req0_valid, req1_valid;
  logic [23:0] req0_code, req1_code;
  logic        req0_ready, req1_ready;
  logic [23:0] code;
  logic        commit, pending, last_src;
  logic [15:0] frame_cnt;

  logic        d4_r0, d4_r1, d4_commit, d4_pending, d4_src;
  logic [23:0] d4_code;
  logic [3:0]  d4_fcnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_code_scheduler u_dut (
    .clk(clk), .rst(rst), .vsync(vsync),
    .req0_valid(req0_valid), .req0_code(req0_code), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_code(req1_code), .req1_ready(req1_ready),
    .code(code), .commit(commit), .pending(pending), .last_src(last_src),
    .frame_cnt(frame_cnt)
  );

  vga_code_scheduler #(.FCNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .vsync(vsync),
    .req0_valid(1'b0), .req0_code(24'h000000), .req0_ready(d4_r0),
    .req1_valid(1'b0), .req1_code(24'h000000), .req1_ready(d4_r1),
    .code(d4_code), .commit(d4_commit), .pending(d4_pending), .last_src(d4_src),
    .frame_cnt(d4_fcnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst; logic vs;
    logic v0; logic [23:0] c0; logic v1; logic [23:0] c1;
    logic r0; logic r1; logic creg;
    logic [23:0] code; logic commit; logic pend; logic src; logic [15:0] fcnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic rs, input logic vs, input logic v0, input logic [23:0] c0,
                              input logic v1, input logic [23:0] c1, input logic r0, input logic r1,
                              input logic creg, input logic [23:0] cd, input logic cm, input logic pd,
                              input logic sr, input logic [15:0] fc);
    vec_t v;
    v.rst = rs; v.vs = vs; v.v0 = v0; v.c0 = c0; v.v1 = v1; v.c1 = c1;
    v.r0 = r0; v.r1 = r1; v.creg = creg; v.code = cd; v.commit = cm;
    v.pend = pd; v.src = sr; v.fcnt = fc;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic        m_pend, m_commit, m_src, m_vs_prev, m_pref1;
  logic [23:0] m_shadow, m_code;
  logic [15:0] m_fcnt;
  logic        e0, e1;

  // Which requester the scheduler should be offering a slot to right now.
  task automatic model_ready();
    e0 = 1'b0; e1 = 1'b0;
    if (!rst && !m_pend) begin
      if (req0_valid && req1_valid) begin
        if (m_pref1) e1 = 1'b1; else e0 = 1'b1;
      end else begin
        e0 = req0_valid;
        e1 = req1_valid;
      end
    end
  endtask

  // Effect of one clock edge with the current inputs.
  task automatic model_step();
    logic fall;
    if (rst) begin
      m_pend = 1'b0; m_code = 24'h000000; m_commit = 1'b0; m_src = 1'b0;
      m_fcnt = 16'd0; m_vs_prev = 1'b1; m_pref1 = 1'b0;
    end else begin
      fall = m_vs_prev && !vsync;
      m_commit = 1'b0;
      if (fall) m_fcnt = m_fcnt + 16'd1;
      if (m_pend) begin
        if (fall) begin
          m_code = m_shadow; m_commit = 1'b1; m_pend = 1'b0;
        end
      end else if ((req0_valid && e0) || (req1_valid && e1)) begin
        m_shadow = e1 ? req1_code : req0_code;
        m_src    = e1;
        m_pref1  = e0;
        m_pend   = 1'b1;
      end
      m_vs_prev = vsync;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vsync = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_code = 24'h000000; req1_code = 24'h000000;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [23:0] exp_codes [4];
    int ncommit;
    int vpos, vlen, vlow;
    logic acc0, acc1;

    rst = 1'b1; vsync = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_code = 24'h000000; req1_code = 24'h000000;

    // ---- directed table: reset, single write, backpressure, edge coincidence ----
    tbl[0]  = mk(1,1, 1,24'hF000F0, 1,24'h222222, 0,0, 0, 24'h000000,0,0,0,16'd0);
    tbl[1]  = mk(1,1, 1,24'hF000F0, 1,24'h222222, 0,0, 1, 24'h000000,0,0,0,16'd0);
    tbl[2]  = mk(1,1, 1,24'hF000F0, 1,24'h222222, 0,0, 1, 24'h000000,0,0,0,16'd0);
    tbl[3]  = mk(0,1, 1,24'hF000F0, 1,24'h222222, 1,0, 1, 24'h000000,0,0,0,16'd0);
    tbl[4]  = mk(0,1, 0,24'hF000F0, 1,24'h222222, 0,0, 1, 24'h000000,0,1,0,16'd0);
    tbl[5]  = mk(0,0, 0,24'hF000F0, 1,24'h222222, 0,0, 1, 24'h000000,0,1,0,16'd0);
    tbl[6]  = mk(0,0, 0,24'hF000F0, 1,24'h222222, 0,1, 1, 24'hF000F0,1,0,0,16'd1);
    tbl[7]  = mk(0,1, 0,24'h000000, 0,24'h000000, 0,0, 1, 24'hF000F0,0,1,1,16'd1);
    tbl[8]  = mk(0,1, 0,24'h000000, 0,24'h000000, 0,0, 1, 24'hF000F0,0,1,1,16'd1);
    tbl[9]  = mk(0,0, 0,24'h000000, 0,24'h000000, 0,0, 1, 24'hF000F0,0,1,1,16'd1);
    tbl[10] = mk(0,1, 0,24'h000000, 0,24'h000000, 0,0, 1, 24'h222222,1,0,1,16'd2);
    tbl[11] = mk(0,0, 1,24'h0ABCDE, 0,24'h000000, 1,0, 1, 24'h222222,0,0,1,16'd2);
    tbl[12] = mk(0,1, 0,24'h000000, 0,24'h000000, 0,0, 1, 24'h222222,0,1,0,16'd3);
    tbl[13] = mk(0,1, 0,24'h000000, 0,24'h000000, 0,0, 1, 24'h222222,0,1,0,16'd3);
    tbl[14] = mk(0,0, 0,24'h000000, 0,24'h000000, 0,0, 1, 24'h222222,0,1,0,16'd3);
    tbl[15] = mk(0,1, 0,24'h000000, 0,24'h000000, 0,0, 1, 24'h0ABCDE,1,0,0,16'd4);
    tbl[16] = mk(0,1, 0,24'h000000, 0,24'h000000, 0,0, 1, 24'h0ABCDE,0,0,0,16'd4);
    tbl[17] = mk(0,0, 0,24'h000000, 0,24'h000000, 0,0, 1, 24'h0ABCDE,0,0,0,16'd4);
    tbl[18] = mk(0,1, 0,24'h000000, 0,24'h000000, 0,0, 1, 24'h0ABCDE,0,0,0,16'd5);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; vsync = tbl[i].vs;
      req0_valid = tbl[i].v0; req0_code = tbl[i].c0;
      req1_valid = tbl[i].v1; req1_code = tbl[i].c1;
      #1;
      chk($sformatf("tbl%0d_ready0", i), req0_ready, tbl[i].r0);
      chk($sformatf("tbl%0d_ready1", i), req1_ready, tbl[i].r1);
      if (tbl[i].creg) begin
        chk($sformatf("tbl%0d_code", i), code, tbl[i].code);
        chk($sformatf("tbl%0d_commit", i), commit, tbl[i].commit);
        chk($sformatf("tbl%0d_pending", i), pending, tbl[i].pend);
        chk($sformatf("tbl%0d_last_src", i), last_src, tbl[i].src);
        chk($sformatf("tbl%0d_frame_cnt", i), frame_cnt, tbl[i].fcnt);
      end
    end

    // ---- contention across 4 frames: commits alternate req0/req1 ----
    exp_codes[0] = 24'h111111; exp_codes[1] = 24'h222222;
    exp_codes[2] = 24'h111111; exp_codes[3] = 24'h222222;
    do_reset();
    ncommit = 0;
    for (int p = 0; p < 80; p++) begin
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b1; req0_code = 24'h111111;
      req1_valid = 1'b1; req1_code = 24'h222222;
      vsync = ((p % 20) >= 18) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("contend_commit_p%0d", p), commit, ((p % 20) == 19) ? 1'b1 : 1'b0);
      if (commit && ncommit < 4) begin
        chk($sformatf("contend_code%0d", ncommit), code, exp_codes[ncommit]);
        chk($sformatf("contend_src%0d", ncommit), last_src, ncommit[0]);
        ncommit++;
      end
    end
    chk("contend_commit_count", ncommit, 4);

    // ---- reset while a word is pending: word lost, no commit pulse ----
    do_reset();
    @(negedge clk);
    rst = 1'b0; vsync = 1'b1;
    req0_valid = 1'b1; req0_code = 24'hABCABC;
    #1 chk("rstpend_ready0", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1 chk("rstpend_pending", pending, 1'b1);
    @(negedge clk);
    rst = 1'b1; vsync = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rst = 1'b0;
      vsync = (k == 2 || k == 3) ? 1'b1 : 1'b0;
      #1;
      chk($sformatf("rstpend_code_k%0d", k), code, 24'h000000);
      chk($sformatf("rstpend_commit_k%0d", k), commit, 1'b0);
      chk($sformatf("rstpend_pend_k%0d", k), pending, 1'b0);
    end

    // ---- frame counter wrap: 17 frames on the 4-bit instance ----
    do_reset();
    for (int f = 0; f < 17; f++) begin
      @(negedge clk); rst = 1'b0; vsync = 1'b1;
      @(negedge clk); vsync = 1'b1;
      @(negedge clk); vsync = 1'b0;
    end
    @(negedge clk);
    vsync = 1'b1;
    #1;
    chk("wrap_fcnt4", d4_fcnt, 4'd1);
    chk("wrap_fcnt16", frame_cnt, 16'd17);

    // ---- randomized traffic against the reference model ----
    req0_valid = 1'b0; req1_valid = 1'b0;
    vpos = 0; vlen = 12; vlow = 2;
    acc0 = 1'b0; acc1 = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
      vsync = (vpos < vlen - vlow) ? 1'b1 : 1'b0;
      vpos++;
      if (vpos >= vlen) begin
        vpos = 0;
        vlen = $urandom_range(6, 30);
        vlow = $urandom_range(1, 3);
      end
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      if (!req0_valid && ($urandom_range(0, 2) == 0)) begin
        req0_valid = 1'b1; req0_code = 24'($urandom);
      end
      if (!req1_valid && ($urandom_range(0, 2) == 0)) begin
        req1_valid = 1'b1; req1_code = 24'($urandom);
      end
      #1;
      model_ready();
      chk("rnd_ready0", req0_ready, e0);
      chk("rnd_ready1", req1_ready, e1);
      if (cyc > 0) begin
        chk("rnd_code", code, m_code);
        chk("rnd_commit", commit, m_commit);
        chk("rnd_pending", pending, m_pend);
        chk("rnd_last_src", last_src, m_src);
        chk("rnd_frame_cnt", frame_cnt, m_fcnt);
      end
      acc0 = req0_valid && e0;
      acc1 = req1_valid && e1;
      model_step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_code_scheduler.md
Name: vga_code_scheduler

Overview:
- Sequences updates of the 24-bit two-colour code word consumed by the 640x480@60 VGA controller. Two requesters (host register path, pattern generator) arbitrate round-robin for a single-entry shadow buffer.
- The accepted code is committed to the VGA `code` input only on the falling edge of VSYNC, so a colour change never tears mid-frame.
- Also counts frames for software pacing.

Parameters:
- CODE_W, 24, width of the code word (two RGB444 colours: left[23:12], right[11:0]).
- RESET_CODE, 24'h000000, value driven on `code` out of reset.
- FCNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  pixel clock, same clock as the VGA controller
- rst  in  1  synchronous, active-high reset
- vsync  in  1  active-low VSYNC from the VGA controller
- req0_valid  in  1  requester 0 has a code word
- req0_code  in  CODE_W  requester 0 code word
- req0_ready  out  1  requester 0 word accepted this cycle when valid&&ready
- req1_valid  in  1  requester 1 has a code word
- req1_code  in  CODE_W  requester 1 code word
- req1_ready  out  1  requester 1 word accepted this cycle when valid&&ready
- code  out  CODE_W  registered code word to the VGA controller
- commit  out  1  one-cycle pulse, high in the cycle `code` takes a new value
- pending  out  1  shadow buffer holds an uncommitted word
- last_src  out  1  source id of the most recently accepted word
- frame_cnt  out  FCNT_W  number of VSYNC falling edges since reset

Behaviour:
- Reset values, with rst high at the clock edge:
  - code=RESET_CODE, commit=0, pending=0, last_src=0, frame_cnt=0.
  - Arbiter pointer favours req0. vsync_d=1. State IDLE. Shadow is discarded.
  - req0_ready and req1_ready are forced to 0 while rst is high.
- VSYNC edge detect: vsync_d registers vsync. vs_fall = vsync_d & ~vsync.
- frame_cnt increments by 1 on every vs_fall in any state. It wraps from 2^FCNT_W-1 to 0.
- States:
  - IDLE (pending=0): ready may assert.
  - PEND (pending=1): both readies are 0 and the shadow is held.
- Arbitration (combinational, IDLE only):
  - Only one valid: that requester gets ready.
  - Both valid: the requester not granted last time wins; the first contention after reset goes to req0.
  - The pointer updates only on an accepted transfer.
- Handshake rules:
  - ready may depend combinationally on valid. Requesters must not make valid depend on ready.
  - A requester must hold valid and code stable until accepted.
  - At most one ready is high in any cycle.
- Accept (IDLE, granted valid&&ready): shadow<=that code, last_src<=id, next state PEND.
- Commit (PEND and vs_fall): code<=shadow, commit<=1 for exactly one cycle, next state IDLE.
  - Earliest new accept is the cycle after commit.
  - Latency from accept to `code` change is 1 cycle after the next vs_fall edge cycle.
- Simultaneous accept and vs_fall in IDLE: the word is accepted and waits for the following vs_fall. It is not committed in the same frame. frame_cnt still increments.
- vs_fall in IDLE: no change to code, commit stays 0.
- vsync held low for multiple cycles (the 2-line sync pulse): only the first low cycle is an edge.
- rst mid-PEND: the pending word is lost and code returns to RESET_CODE. No commit pulse is generated.
- The arithmetic is unsigned, and no other saturation exists.

Decomposition:
- Shared package vga_ctrl_pkg holds:
  - CODE_W, and the state enum (IDLE, PEND).
  - VGA timing constants: H_TOTAL=800, V_TOTAL=525, V_VISIBLE=480, V_FP=10, V_SYNC=2. These are for benches and sibling blocks.
- One sub-module, rr_arb2: a 2-way round-robin arbiter.
  - Inputs: clk, rst, req[1:0], advance.
  - Output: one-hot gnt[1:0].
  - The pointer is updated on `advance`.
- The FSM, edge detect, shadow register and frame counter live in vga_code_scheduler.

Test Plan:
- Reset: hold rst 3 cycles with both valids high -> both readies 0, code=24'h000000, frame_cnt=0, pending=0. After release, req0_ready=1 first.
- Single write: req0 valid with 24'hF00_0F0 in IDLE -> accepted in 1 cycle, pending=1.
  - code unchanged until vs_fall. One cycle after the vs_fall cycle, code=24'hF000F0 and commit=1 for exactly 1 cycle.
  - Then pending=0.
- Contention: both valid continuously (req0=24'h111111, req1=24'h222222) across 4 frames -> accepts alternate req0, req1, req0, req1.
  - last_src sequence is 0,1,0,1. code sequence is 111111, 222222, 111111, 222222.
  - Exactly one commit per frame.
- Backpressure: req1 valid while PEND -> req1_ready stays 0 until the cycle after commit. The word is not lost, and is accepted then committed on the next vs_fall.
- Edge coincidence: accept in the same cycle as vs_fall -> no commit that frame; commit on the following vs_fall. frame_cnt increments on both edges.
- Reset mid-PEND and counter wrap:
  - Accept 24'hABCABC, assert rst before vs_fall -> code=000000, pending=0, no commit pulse.
  - Separately, with FCNT_W=4, 17 frames -> frame_cnt=1.
